// File: rtl/prog_loader.sv
// Byte-stream program loader: frames of big-endian words are written into MIPS instruction
// memory from address 0, then the core is switched to run mode. Optional macro: LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 8,
  parameter int         RST_HOLD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ProgMode,
  output logic [ADDR_W-1:0] Addr_Prog,
  output logic [31:0]       Data_Prog,
  output logic              prog_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              error
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_DATA    = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CKSUM   = 3'd6,
    S_ERROR   = 3'd7,
`endif
    S_RUN     = 3'd5
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                accept_s;
  logic                is_sync_s;
  logic [1:0]          byte_idx_r;
  logic [8:0]          word_cnt_r;
  logic [ADDR_W-1:0]   next_addr_r;
  logic [23:0]         asm_r;
  logic [HOLD_W-1:0]   hold_r;
  logic                rx_ready_r;
  logic                prog_mode_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         data_r;
  logic                we_r;
  logic                cpu_rst_r;
  logic                busy_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          cksum_r;
  logic                err_r;
`endif

  assign accept_s  = rx_valid & rx_ready_r;
  assign is_sync_s = (rx_data == SYNC_BYTE);

  assign rx_ready  = rx_ready_r;
  assign ProgMode  = prog_mode_r;
  assign Addr_Prog = addr_r;
  assign Data_Prog = data_r;
  assign prog_we   = we_r;
  assign cpu_reset = cpu_rst_r;
  assign busy      = busy_r;
`ifdef LOADER_CHECKSUM_EN
  assign error     = err_r;
`else
  assign error     = 1'b0;
`endif

  // Next-state decode; every byte consumption is gated by accept_s.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && is_sync_s) next_state_s = S_COUNT;
        else                       next_state_s = state_r;
      end
      S_COUNT: begin
        if (accept_s) next_state_s = S_DATA;
        else          next_state_s = state_r;
      end
      S_DATA: begin
        if (accept_s && (byte_idx_r == 2'd3)) next_state_s = S_WRITE;
        else                                  next_state_s = state_r;
      end
      S_WRITE: begin
        if (word_cnt_r == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
          next_state_s = S_CKSUM;
`else
          next_state_s = S_RELEASE;
`endif
        end else begin
          next_state_s = S_DATA;
        end
      end
      S_RELEASE: begin
        if (hold_r == HOLD_LAST) next_state_s = S_RUN;
        else                     next_state_s = state_r;
      end
      S_RUN: begin
        if (accept_s && is_sync_s) next_state_s = S_COUNT;
        else                       next_state_s = state_r;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (accept_s) begin
          if (rx_data == cksum_r) next_state_s = S_RELEASE;
          else                    next_state_s = S_ERROR;
        end else begin
          next_state_s = state_r;
        end
      end
      S_ERROR: begin
        if (accept_s && is_sync_s) next_state_s = S_COUNT;
        else                       next_state_s = state_r;
      end
`endif
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register plus outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      rx_ready_r  <= 1'b1;
      prog_mode_r <= 1'b0;
      addr_r      <= '0;
      data_r      <= 32'h0000_0000;
      we_r        <= 1'b0;
      cpu_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
      byte_idx_r  <= 2'd0;
      word_cnt_r  <= 9'd0;
      next_addr_r <= '0;
      asm_r       <= 24'h00_0000;
      hold_r      <= '0;
`ifdef LOADER_CHECKSUM_EN
      cksum_r     <= 8'h00;
      err_r       <= 1'b0;
`endif
    end else begin
      state_r     <= next_state_s;
      rx_ready_r  <= (next_state_s != S_WRITE) && (next_state_s != S_RELEASE);
      prog_mode_r <= (next_state_s == S_RELEASE) || (next_state_s == S_RUN);
      we_r        <= (next_state_s == S_WRITE);
`ifdef LOADER_CHECKSUM_EN
      busy_r      <= (next_state_s == S_COUNT) || (next_state_s == S_DATA) ||
                     (next_state_s == S_WRITE) || (next_state_s == S_CKSUM) ||
                     (next_state_s == S_RELEASE);
      cpu_rst_r   <= (next_state_s == S_IDLE) || (next_state_s == S_RELEASE) ||
                     (next_state_s == S_ERROR);
      err_r       <= (next_state_s == S_ERROR);
`else
      busy_r      <= (next_state_s == S_COUNT) || (next_state_s == S_DATA) ||
                     (next_state_s == S_WRITE) || (next_state_s == S_RELEASE);
      cpu_rst_r   <= (next_state_s == S_IDLE) || (next_state_s == S_RELEASE);
`endif
      if (state_r == S_RELEASE) hold_r <= hold_r + 1'b1;
      else                      hold_r <= '0;

      case (state_r)
        S_COUNT: begin
          if (accept_s) begin
            word_cnt_r  <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            byte_idx_r  <= 2'd0;
            next_addr_r <= '0;
`ifdef LOADER_CHECKSUM_EN
            cksum_r     <= 8'h00;
`endif
          end
        end
        S_DATA: begin
          // Data_Prog only changes together with the strobe, never mid-assembly.
          if (accept_s) begin
            asm_r      <= {asm_r[15:0], rx_data};
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            cksum_r    <= cksum_r ^ rx_data;
`endif
            if (byte_idx_r == 2'd3) begin
              data_r <= {asm_r, rx_data};
              addr_r <= next_addr_r;
            end
          end
        end
        S_WRITE: begin
          next_addr_r <= next_addr_r + 1'b1;
          word_cnt_r  <= word_cnt_r - 9'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
